// File: rtl/lsu_mem_arbiter_if.sv
// Bundle between the per-thread LSU ports, the arbiter and the shared memory channels.
// slave: arbiter view; master: the LSU plus memory environment driving it.
interface lsu_mem_arbiter_if #(
    parameter int NUM_THREADS  = 4,
    parameter int NUM_CHANNELS = 1,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8
);
    logic [NUM_THREADS-1:0]            thread_read_request;
    logic [NUM_THREADS*ADDR_BITS-1:0]  thread_read_address;
    logic [NUM_THREADS-1:0]            thread_read_ready;
    logic [NUM_THREADS*DATA_BITS-1:0]  thread_read_data;
    logic [NUM_THREADS-1:0]            thread_write_request;
    logic [NUM_THREADS*ADDR_BITS-1:0]  thread_write_address;
    logic [NUM_THREADS*DATA_BITS-1:0]  thread_write_data;
    logic [NUM_THREADS-1:0]            thread_write_ready;

    logic [NUM_CHANNELS-1:0]           mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]           mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]           mem_write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]           mem_write_ready;

    modport slave (
        input  thread_read_request, thread_read_address,
        input  thread_write_request, thread_write_address, thread_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output thread_read_ready, thread_read_data, thread_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    modport master (
        output thread_read_request, thread_read_address,
        output thread_write_request, thread_write_address, thread_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  thread_read_ready, thread_read_data, thread_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter of NUM_THREADS LSU ports onto NUM_CHANNELS memory channels (optional ARB_PERF_COUNTERS_EN).
// Latency: grant, valid, memory ready sampled, then a one-cycle thread ready pulse (3 cycles minimum).
// Backpressure: channel holds valid until mem ready; a served thread stays claimed until its request drops.
module lsu_mem_arbiter #(
    parameter int NUM_THREADS  = 4,
    parameter int NUM_CHANNELS = 1,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic               clk,
    input  logic               reset,
    lsu_mem_arbiter_if.slave   bus
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]        perf_grants,
    output logic [31:0]        perf_stall_cycles
`endif
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_WRITE_WAIT,
        ST_RELEASE
    } ch_state_e;

    ch_state_e                        st_q   [NUM_CHANNELS];
    ch_state_e                        st_d   [NUM_CHANNELS];
    logic [TW-1:0]                    tid_q  [NUM_CHANNELS];
    logic [TW-1:0]                    tid_d  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]             addr_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]             addr_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0]             wdat_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]             wdat_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]          op_rd_q, op_rd_d;
    logic [NUM_CHANNELS-1:0]          rd_vld_q, rd_vld_d;
    logic [NUM_CHANNELS-1:0]          wr_vld_q, wr_vld_d;
    logic [NUM_THREADS-1:0]           rd_rdy_q, rd_rdy_d;
    logic [NUM_THREADS-1:0]           wr_rdy_q, wr_rdy_d;
    logic [NUM_THREADS*DATA_BITS-1:0] rd_dat_q, rd_dat_d;
    logic [TW-1:0]                    rr_ptr_q, rr_ptr_d;

    logic [NUM_THREADS-1:0]           req_any;
    logic [NUM_THREADS-1:0]           claimed;
    logic [NUM_THREADS-1:0]           claim;
    logic                             found;
    int                               pick;
    int                               pk;
    int                               idx;
    int                               tid;
    int                               last_k;
`ifdef ARB_PERF_COUNTERS_EN
    int                               n_grants;
    logic                             stall;
    logic [31:0]                      perf_grants_q, perf_grants_d;
    logic [31:0]                      perf_stall_q, perf_stall_d;
`endif

    function automatic int wrap_idx(input int v);
        return (v >= NUM_THREADS) ? v - NUM_THREADS : v;
    endfunction

    assign req_any = bus.thread_read_request | bus.thread_write_request;

    // A thread is owned by a channel from its grant until the channel leaves RELEASE.
    always_comb begin
        claimed = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (st_q[c] != ST_IDLE) begin
                claimed[tid_q[c]] = 1'b1;
            end
        end
    end

    always_comb begin
        st_d     = st_q;
        tid_d    = tid_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        op_rd_d  = op_rd_q;
        rd_vld_d = rd_vld_q;
        wr_vld_d = wr_vld_q;
        rd_rdy_d = '0;
        wr_rdy_d = '0;
        rd_dat_d = rd_dat_q;
        rr_ptr_d = rr_ptr_q;
        claim    = claimed;
        found    = 1'b0;
        pick     = 0;
        pk       = 0;
        idx      = 0;
        tid      = 0;
        last_k   = -1;
`ifdef ARB_PERF_COUNTERS_EN
        n_grants = 0;
        stall    = 1'b0;
`endif
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            tid = int'(tid_q[c]);
            case (st_q[c])
                ST_IDLE: begin
                    // Claims made by lower channels this cycle are already in claim.
                    found = 1'b0;
                    for (int k = 0; k < NUM_THREADS; k++) begin
                        idx = wrap_idx(int'(rr_ptr_q) + k);
                        if (!found && req_any[idx] && !claim[idx]) begin
                            found = 1'b1;
                            pick  = idx;
                            pk    = k;
                        end
                    end
                    if (found) begin
                        claim[pick] = 1'b1;
                        tid_d[c]    = TW'(pick);
                        wdat_d[c]   = bus.thread_write_data[pick*DATA_BITS +: DATA_BITS];
                        last_k      = pk;
`ifdef ARB_PERF_COUNTERS_EN
                        n_grants    = n_grants + 1;
`endif
                        if (bus.thread_read_request[pick]) begin
                            op_rd_d[c]  = 1'b1;
                            addr_d[c]   = bus.thread_read_address[pick*ADDR_BITS +: ADDR_BITS];
                            rd_vld_d[c] = 1'b1;
                            st_d[c]     = ST_READ_WAIT;
                        end else begin
                            op_rd_d[c]  = 1'b0;
                            addr_d[c]   = bus.thread_write_address[pick*ADDR_BITS +: ADDR_BITS];
                            wr_vld_d[c] = 1'b1;
                            st_d[c]     = ST_WRITE_WAIT;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (bus.mem_read_ready[c]) begin
                        rd_vld_d[c]                          = 1'b0;
                        rd_rdy_d[tid]                        = 1'b1;
                        rd_dat_d[tid*DATA_BITS +: DATA_BITS] = bus.mem_read_data[c*DATA_BITS +: DATA_BITS];
                        st_d[c]                              = ST_RELEASE;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (bus.mem_write_ready[c]) begin
                        wr_vld_d[c]   = 1'b0;
                        wr_rdy_d[tid] = 1'b1;
                        st_d[c]       = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Only the request that was served must drop; a pending other-op request waits.
                    if (op_rd_q[c] ? !bus.thread_read_request[tid] : !bus.thread_write_request[tid]) begin
                        st_d[c] = ST_IDLE;
                    end
                end
                default: st_d[c] = ST_IDLE;
            endcase
        end
        if (last_k >= 0) begin
            rr_ptr_d = TW'(wrap_idx(int'(rr_ptr_q) + last_k + 1));
        end
`ifdef ARB_PERF_COUNTERS_EN
        stall         = |(req_any & ~claim);
        perf_grants_d = perf_grants_q + 32'(n_grants);
        perf_stall_d  = perf_stall_q + {31'b0, stall};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                st_q[c]   <= ST_IDLE;
                tid_q[c]  <= '0;
                addr_q[c] <= '0;
                wdat_q[c] <= '0;
            end
            op_rd_q  <= '0;
            rd_vld_q <= '0;
            wr_vld_q <= '0;
            rd_rdy_q <= '0;
            wr_rdy_q <= '0;
            rd_dat_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                st_q[c]   <= st_d[c];
                tid_q[c]  <= tid_d[c];
                addr_q[c] <= addr_d[c];
                wdat_q[c] <= wdat_d[c];
            end
            op_rd_q  <= op_rd_d;
            rd_vld_q <= rd_vld_d;
            wr_vld_q <= wr_vld_d;
            rd_rdy_q <= rd_rdy_d;
            wr_rdy_q <= wr_rdy_d;
            rd_dat_q <= rd_dat_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ARB_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_grants_q <= perf_grants_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_grants       = perf_grants_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

    assign bus.thread_read_ready  = rd_rdy_q;
    assign bus.thread_read_data   = rd_dat_q;
    assign bus.thread_write_ready = wr_rdy_q;
    assign bus.mem_read_valid     = rd_vld_q;
    assign bus.mem_write_valid    = wr_vld_q;

    for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_ch_out
        assign bus.mem_read_address[gc*ADDR_BITS +: ADDR_BITS]  = addr_q[gc];
        assign bus.mem_write_address[gc*ADDR_BITS +: ADDR_BITS] = addr_q[gc];
        assign bus.mem_write_data[gc*DATA_BITS +: DATA_BITS]    = wdat_q[gc];
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench: one 4-thread/1-channel arbiter and one 4-thread/2-channel arbiter on a shared clock.
module tb_lsu_mem_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    logic       mem_en;
    logic       man_rdy;
    logic [7:0] man_dat;
    logic       p1r, p1w;
    logic [1:0] p2r, p2w;

    lsu_mem_arbiter_if #(.NUM_THREADS(4), .NUM_CHANNELS(1)) b1 ();
    lsu_mem_arbiter_if #(.NUM_THREADS(4), .NUM_CHANNELS(2)) b2 ();

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] pg1, ps1, pg2, ps2;
`endif

    lsu_mem_arbiter #(.NUM_THREADS(4), .NUM_CHANNELS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
`ifdef ARB_PERF_COUNTERS_EN
        ,
        .perf_grants       (pg1),
        .perf_stall_cycles (ps1)
`endif
    );

    lsu_mem_arbiter #(.NUM_THREADS(4), .NUM_CHANNELS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
`ifdef ARB_PERF_COUNTERS_EN
        ,
        .perf_grants       (pg2),
        .perf_stall_cycles (ps2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ready on the second cycle of valid, read data = address ^ 0x99.
    initial begin
        p1r = 1'b0; p1w = 1'b0; p2r = '0; p2w = '0;
        b1.mem_read_ready = '0; b1.mem_write_ready = '0; b1.mem_read_data = '0;
        b2.mem_read_ready = '0; b2.mem_write_ready = '0; b2.mem_read_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_en) begin
                b1.mem_read_ready  = b1.mem_read_valid & p1r;
                b1.mem_write_ready = b1.mem_write_valid & p1w;
                b1.mem_read_data   = b1.mem_read_address ^ 8'h99;
                b2.mem_read_ready  = b2.mem_read_valid & p2r;
                b2.mem_write_ready = b2.mem_write_valid & p2w;
                b2.mem_read_data   = b2.mem_read_address ^ 16'h9999;
            end else begin
                b1.mem_read_ready  = man_rdy;
                b1.mem_read_data   = man_dat;
                b1.mem_write_ready = 1'b0;
                b2.mem_read_ready  = '0;
                b2.mem_write_ready = '0;
            end
            p1r = b1.mem_read_valid;
            p1w = b1.mem_write_valid;
            p2r = b2.mem_read_valid;
            p2w = b2.mem_write_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        b1.thread_read_request  = '0; b1.thread_read_address  = '0;
        b1.thread_write_request = '0; b1.thread_write_address = '0;
        b1.thread_write_data    = '0;
        b2.thread_read_request  = '0; b2.thread_read_address  = '0;
        b2.thread_write_request = '0; b2.thread_write_address = '0;
        b2.thread_write_data    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        zero_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int got;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    bit reraise;
    bit rearmed;

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        mem_en  = 1'b1;
        man_rdy = 1'b0;
        man_dat = 8'h00;
        zero_inputs();
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", b1.mem_read_valid, 1'b0);
        chk("rst_wr_valid", b1.mem_write_valid, 1'b0);
        chk("rst_rd_ready", b1.thread_read_ready, 4'h0);
        chk("rst_wr_ready", b1.thread_write_ready, 4'h0);
        chk("rst_rd_data", b1.thread_read_data, 32'h0);
        chk("rst_rr_ptr", dut1.rr_ptr_q, 2'd0);
        chk("rst_b2_valid", {b2.mem_read_valid, b2.mem_write_valid}, 4'h0);
        reset = 1'b0;

        // Thread 2 reads 0x3C; memory answers 0xA5.
        do_reset();
        b1.thread_read_address = 32'h003C_0000;
        b1.thread_read_request = 4'b0100;
        @(negedge clk);
        chk("t1_valid_c1", b1.mem_read_valid, 1'b1);
        chk("t1_addr", b1.mem_read_address, 8'h3C);
        chk("t1_rdy_c1", b1.thread_read_ready, 4'h0);
        @(negedge clk);
        chk("t1_valid_c2", b1.mem_read_valid, 1'b1);
        @(negedge clk);
        chk("t1_rdy_pulse", b1.thread_read_ready, 4'b0100);
        chk("t1_data", b1.thread_read_data[23:16], 8'hA5);
        @(negedge clk);
        chk("t1_rdy_once", b1.thread_read_ready, 4'h0);
        chk("t1_no_revalid_c4", b1.mem_read_valid, 1'b0);
        @(negedge clk);
        chk("t1_no_revalid_c5", b1.mem_read_valid, 1'b0);
        chk("t1_data_held", b1.thread_read_data[23:16], 8'hA5);
        b1.thread_read_request = '0;
        @(negedge clk);
        chk("t1_idle_after", b1.mem_read_valid, 1'b0);

        // All four threads read on one channel; thread 0 re-requests after its release.
        do_reset();
        b1.thread_read_address = 32'h1312_1110;
        b1.thread_read_request = 4'hF;
        got = 0; reraise = 1'b0; rearmed = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            if (reraise) begin
                b1.thread_read_request[0] = 1'b1;
                reraise = 1'b0;
            end
            for (int t = 0; t < 4; t++) begin
                if (b1.thread_read_ready[t]) begin
                    if (got < 5) order[got] = t;
                    got++;
                    chk("t2_data", b1.thread_read_data[t*8 +: 8], (8'h10 + 8'(t)) ^ 8'h99);
                    b1.thread_read_request[t] = 1'b0;
                    if (t == 0 && !rearmed) begin
                        reraise = 1'b1;
                        rearmed = 1'b1;
                    end
                end
            end
        end
        chk("t2_count", got, 5);
        for (int i = 0; i < 5; i++) chk("t2_order", order[i], exp_order[i]);
        b1.thread_read_request = '0;

        // Two channels: threads 1 and 3 write in the same cycle.
        do_reset();
        b2.thread_write_address = 32'h4300_4100;
        b2.thread_write_data    = 32'h2200_1100;
        b2.thread_write_request = 4'b1010;
        @(negedge clk);
        chk("t3_wr_valid", b2.mem_write_valid, 2'b11);
        chk("t3_wr_addr", b2.mem_write_address, 16'h4341);
        chk("t3_wr_data", b2.mem_write_data, 16'h2211);
        chk("t3_rd_valid", b2.mem_read_valid, 2'b00);
        chk("t3_rr_ptr", dut2.rr_ptr_q, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_wr_ready", b2.thread_write_ready, 4'b1010);
        b2.thread_write_request = '0;

        // Read wins over write on the same thread; write waits for the read request to drop.
        do_reset();
        b1.thread_read_address  = 32'h0000_0020;
        b1.thread_write_address = 32'h0000_0021;
        b1.thread_write_data    = 32'h0000_005A;
        b1.thread_read_request  = 4'b0001;
        b1.thread_write_request = 4'b0001;
        @(negedge clk);
        chk("t4_rd_first", b1.mem_read_valid, 1'b1);
        chk("t4_wr_held", b1.mem_write_valid, 1'b0);
        chk("t4_rd_addr", b1.mem_read_address, 8'h20);
        @(negedge clk);
        @(negedge clk);
        chk("t4_rd_ready", b1.thread_read_ready, 4'b0001);
        chk("t4_rd_data", b1.thread_read_data[7:0], 8'hB9);
        @(negedge clk);
        chk("t4_wr_blocked_c4", b1.mem_write_valid, 1'b0);
        @(negedge clk);
        chk("t4_wr_blocked_c5", b1.mem_write_valid, 1'b0);
        b1.thread_read_request = '0;
        @(negedge clk);
        chk("t4_wr_blocked_c6", b1.mem_write_valid, 1'b0);
        @(negedge clk);
        chk("t4_wr_valid", b1.mem_write_valid, 1'b1);
        chk("t4_wr_addr", b1.mem_write_address, 8'h21);
        chk("t4_wr_data", b1.mem_write_data, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        chk("t4_wr_ready", b1.thread_write_ready, 4'b0001);
        chk("t4_no_rd_ready", b1.thread_read_ready, 4'h0);
        b1.thread_write_request = '0;

        // Reset during READ_WAIT drops the transaction; a late memory ready is ignored.
        do_reset();
        mem_en = 1'b0;
        man_rdy = 1'b0;
        b1.thread_read_address = 32'h0000_5500;
        b1.thread_read_request = 4'b0010;
        @(negedge clk);
        chk("t5_valid", b1.mem_read_valid, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        zero_inputs();
        #1;
        chk("t5_async_valid", b1.mem_read_valid, 1'b0);
        chk("t5_async_rdy", b1.thread_read_ready, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        man_rdy = 1'b1;
        man_dat = 8'h77;
        @(negedge clk);
        chk("t5_stale_rdy", b1.thread_read_ready, 4'h0);
        chk("t5_stale_data", b1.thread_read_data[15:8], 8'h00);
        man_rdy = 1'b0;
        @(negedge clk);
        chk("t5_stale_rdy2", b1.thread_read_ready, 4'h0);
        chk("t5_valid_low", b1.mem_read_valid, 1'b0);
        mem_en = 1'b1;
        @(negedge clk);

`ifdef ARB_PERF_COUNTERS_EN
        do_reset();
        chk("t6_grants_rst", pg1, 32'd0);
        chk("t6_stall_rst", ps1, 32'd0);
        b1.thread_read_address = 32'h1312_1110;
        b1.thread_read_request = 4'hF;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            for (int t = 0; t < 4; t++) begin
                if (b1.thread_read_ready[t]) begin
                    got++;
                    b1.thread_read_request[t] = 1'b0;
                end
            end
        end
        chk("t6_count", got, 4);
        chk("t6_grants", pg1, 32'd4);
        chk("t6_stall_nz", (ps1 != 32'd0), 1'b1);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Parametrised data-memory arbiter between the per-thread LSU ports of a core and a smaller set of shared memory channels.
- Generalises the fixed 4-lane, 8-bit, one-port-per-thread data memory interface: NUM_THREADS lanes share NUM_CHANNELS channels.
- Fair round-robin grant, per-channel request tracking, and release handshake so a held thread request is served exactly once.

Parameters:
- NUM_THREADS, 4, number of thread-side LSU ports (>=1).
- NUM_CHANNELS, 1, number of memory-side channels (1..NUM_THREADS).
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- thread_read_request  in  NUM_THREADS  per-thread read request, held until thread_read_ready.
- thread_read_address  in  NUM_THREADS*ADDR_BITS  packed, thread i at [i*ADDR_BITS +: ADDR_BITS].
- thread_read_ready  out  NUM_THREADS  one-cycle completion pulse.
- thread_read_data  out  NUM_THREADS*DATA_BITS  read data, valid with the ready pulse and held until the next completion for that thread.
- thread_write_request  in  NUM_THREADS  per-thread write request, held until thread_write_ready.
- thread_write_address  in  NUM_THREADS*ADDR_BITS  packed write address.
- thread_write_data  in  NUM_THREADS*DATA_BITS  packed write data.
- thread_write_ready  out  NUM_THREADS  one-cycle completion pulse.
- mem_read_valid  out  NUM_CHANNELS  channel read request.
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  channel read address.
- mem_read_ready  in  NUM_CHANNELS  memory read done.
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data.
- mem_write_valid  out  NUM_CHANNELS  channel write request.
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  channel write address.
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  channel write data.
- mem_write_ready  in  NUM_CHANNELS  memory write done.

Behaviour:
- Reset: all outputs 0, every channel IDLE, rr_ptr=0, no threads claimed. Reset mid-transaction drops the transaction; it is not replayed.
- Per-channel FSM IDLE -> READ_WAIT or WRITE_WAIT -> RELEASE -> IDLE.
- IDLE, eligible thread: request high, not claimed by any channel, not in RELEASE.
  - Channel c (ascending order) picks the first eligible thread scanning from rr_ptr upward, mod NUM_THREADS.
  - The thread is claimed immediately, so lower channels have priority within the cycle.
  - Read wins over write when both are high on the chosen thread.
- Grant cycle: latch thread id, op, address and data into channel registers. mem_*_valid asserts on the next cycle and is driven only from those registers.
- Grant pointer: if any grant occurs in a cycle, rr_ptr <= (highest-index-in-scan-order granted thread + 1) mod NUM_THREADS. Otherwise rr_ptr holds.
- READ_WAIT / WRITE_WAIT: hold valid. On mem_*_ready:
  - Drop valid that cycle (registered, so low from the next cycle).
  - Capture read data into thread_read_data[id].
  - Pulse thread_*_ready[id] for exactly one cycle (next cycle).
  - Go to RELEASE.
- Minimum latency, request to ready pulse: 3 cycles with zero-wait memory (grant, valid, ready sampled, pulse).
- RELEASE: thread stays claimed until its corresponding request is observed low, then channel returns to IDLE. This prevents double service of a held request.
- mem ready while the channel is not WAITing is ignored. Thread request dropped before completion is not aborted; completion still pulses.
- Thread count smaller than NUM_THREADS is handled by the LSU holding requests low. No enable input.
- NUM_CHANNELS >= NUM_THREADS: every requester is granted in the same cycle.

Optional Feature:
- Macro ARB_PERF_COUNTERS_EN.
- When defined, adds outputs perf_grants (32 bits) and perf_stall_cycles (32 bits).
  - perf_grants: +1 per grant event, counting each channel separately.
  - perf_stall_cycles: +1 per cycle in which at least one request-high thread is unclaimed and not in RELEASE but received no grant.
  - Both cleared by reset and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Defaults, thread 2 reads 0x3C, memory returns 0xA5 one cycle after valid -> mem_read_address=0x3C. thread_read_ready[2] pulses once with data 0xA5. Request held two more cycles produces no second mem_read_valid.
- Threads 0-3 all read simultaneously, NUM_CHANNELS=1 -> grant order 0,1,2,3. Thread 0 re-requests after release and is served after 3. No thread is served twice before the others.
- NUM_CHANNELS=2, threads 1 and 3 write 0x11/0x22 -> channel 0 serves thread 1 and channel 1 serves thread 3 in the same cycle. rr_ptr=0 afterwards.
- Thread 0 raises read and write together -> read is served first. The write is served only after release, once the read request drops.
- Reset asserted during READ_WAIT -> all valids and readies go low asynchronously. After reset, memory ready for the old transaction produces no thread pulse.
- ARB_PERF_COUNTERS_EN, four simultaneous reads on 1 channel with 1-cycle memory -> perf_grants=4, perf_stall_cycles>0 while requests wait.
